// File: rtl/present_byte_if.sv
`default_nettype none
// present_byte_if -- byte-stream key/plaintext loader and ciphertext drain around present_top.
// Revision: 1.0
module present_byte_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_key,
  output logic        core_start,
  output logic [63:0] core_din,
  output logic [79:0] core_key,
  input  logic [63:0] core_dout,
  input  logic        core_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [2:0]  ocnt_q, ocnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [63:0] din_q, din_d;
  logic [79:0] key_q, key_d;
  logic [63:0] dout_sr_q, dout_sr_d;
  logic        s_ready_q, s_ready_d;
  logic        start_q, start_d;
  logic        m_valid_q, m_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        s_fire;
  logic        m_fire;

  // Handshakes qualify on the registered ready/valid, so no input reaches an output combinationally.
  assign s_fire = s_valid && s_ready_q;
  assign m_fire = m_valid_q && m_ready;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    ocnt_d    = ocnt_q;
    tcnt_d    = tcnt_q;
    din_d     = din_q;
    key_d     = key_q;
    dout_sr_d = dout_sr_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (s_fire) begin
          if (s_key) begin
            key_d = {key_q[71:0], s_data};
          end else begin
            din_d  = {din_q[55:0], s_data};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
              state_d = ST_START;
            end
          end
        end
      end
      ST_START: begin
        tcnt_d  = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + 16'd1;
        // A done arriving on the final timeout cycle still wins.
        if (core_done) begin
          dout_sr_d = core_dout;
          state_d   = ST_DRAIN;
        end else if (tcnt_q == TCNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (m_fire) begin
          dout_sr_d = {dout_sr_q[55:0], 8'h00};
          ocnt_d    = ocnt_q + 3'd1;
          if (ocnt_q == 3'd7) begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
    start_d   = (state_d == ST_START);
    m_valid_d = (state_d == ST_DRAIN);
    busy_d    = (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= 3'd0;
      ocnt_q    <= 3'd0;
      tcnt_q    <= 16'd0;
      din_q     <= 64'd0;
      key_q     <= 80'd0;
      dout_sr_q <= 64'd0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      ocnt_q    <= ocnt_d;
      tcnt_q    <= tcnt_d;
      din_q     <= din_d;
      key_q     <= key_d;
      dout_sr_q <= dout_sr_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign core_start  = start_q;
  assign core_din    = din_q;
  assign core_key    = key_q;
  assign m_valid     = m_valid_q;
  assign m_data      = dout_sr_q[63:56];
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_present_byte_if.sv
`default_nettype none
// tb_present_byte_if -- directed bench for present_byte_if with a behavioural core stand-in.
// Revision: 1.0
module tb_present_byte_if;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_key = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        core_done = 1'b0;
  logic [63:0] core_dout = 64'd0;
  logic        m_ready = 1'b1;
  logic        s_ready, core_start, m_valid, busy, err_timeout;
  logic [63:0] core_din;
  logic [79:0] core_key;
  logic [7:0]  m_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
  localparam logic [63:0] CT_ONES = 64'hE72C46C0F5945049;

  present_byte_if #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key(s_key),
    .core_start(core_start), .core_din(core_din), .core_key(core_key),
    .core_dout(core_dout), .core_done(core_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input bit k, input logic [7:0] d);
    int n;
    n = 0;
    s_valid = 1'b1; s_key = k; s_data = d;
    while (!s_ready && n < 100) begin step(); n++; end
    if (!s_ready) check("s_ready_bound", {79'd0, s_ready}, 80'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic load_key(input logic [79:0] k);
    for (int j = 0; j < 10; j++) send_byte(1'b1, k[79-8*j -: 8]);
  endtask

  task automatic load_pt(input logic [63:0] p, input int first, input int count);
    for (int j = first; j < first + count; j++) send_byte(1'b0, p[63-8*j -: 8]);
  endtask

  // Stand-in for present_top: done arrives lat cycles after the start pulse.
  task automatic core_reply(input int lat, input logic [63:0] ct);
    check("start_on", {79'd0, core_start}, 80'd1);
    check("start_busy", {79'd0, busy}, 80'd1);
    step();
    check("start_pulse_off", {79'd0, core_start}, 80'd0);
    for (int c = 1; c < lat; c++) step();
    core_done = 1'b1; core_dout = ct;
    step();
    core_done = 1'b0; core_dout = 64'd0;
  endtask

  task automatic drain(input logic [63:0] ct, input bit bp);
    int i, cyc;
    i = 0; cyc = 0;
    check("drain_first_valid", {79'd0, m_valid}, 80'd1);
    while (i < 8 && cyc < 200) begin
      m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      check("drain_valid", {79'd0, m_valid}, 80'd1);
      check("drain_data", {72'd0, m_data}, {72'd0, ct[63-8*i -: 8]});
      check("drain_s_ready", {79'd0, s_ready}, 80'd0);
      check("drain_busy", {79'd0, busy}, 80'd1);
      if (m_ready) i++;
      step();
      cyc++;
    end
    m_ready = 1'b1;
    check("drain_count", i, 80'd8);
    check("drain_end_valid", {79'd0, m_valid}, 80'd0);
    check("drain_end_ready", {79'd0, s_ready}, 80'd1);
    check("drain_end_busy", {79'd0, busy}, 80'd0);
  endtask

  task automatic reset_pulse();
    RST = 1'b0;
    #2;
    check("rst_s_ready", {79'd0, s_ready}, 80'd0);
    check("rst_start", {79'd0, core_start}, 80'd0);
    check("rst_din", {16'd0, core_din}, 80'd0);
    check("rst_key", core_key, 80'd0);
    check("rst_m_valid", {79'd0, m_valid}, 80'd0);
    check("rst_m_data", {72'd0, m_data}, 80'd0);
    check("rst_busy", {79'd0, busy}, 80'd0);
    check("rst_err", {79'd0, err_timeout}, 80'd0);
    @(posedge CLK); #1;
    RST = 1'b1;
    check("idle_not_ready", {79'd0, s_ready}, 80'd0);
    step();
    check("load_ready", {79'd0, s_ready}, 80'd1);
  endtask

  initial begin
    reset_pulse();

    // Basic all-zero vector
    load_key(80'd0);
    load_pt(64'd0, 0, 8);
    check("basic_din", {16'd0, core_din}, 80'd0);
    core_reply(5, CT_ZERO);
    drain(CT_ZERO, 1'b0);

    // Key reuse across two blocks
    load_key({80{1'b1}});
    for (int b = 0; b < 2; b++) begin
      load_pt(64'd0, 0, 8);
      check("reuse_key", core_key, {80{1'b1}});
      core_reply(3, CT_ONES);
      drain(CT_ONES, 1'b0);
    end

    // More than ten key bytes, then backpressure with a held input byte
    send_byte(1'b1, 8'hDE);
    send_byte(1'b1, 8'hAD);
    load_key(80'h00112233445566778899);
    load_pt(64'h0123456789ABCDEF, 0, 8);
    check("bp_key", core_key, 80'h00112233445566778899);
    check("bp_din", {16'd0, core_din}, {16'd0, 64'h0123456789ABCDEF});
    core_reply(2, 64'hA1B2C3D4E5F60718);
    s_valid = 1'b1; s_key = 1'b0; s_data = 8'h5A;
    drain(64'hA1B2C3D4E5F60718, 1'b1);
    step();
    s_valid = 1'b0;
    load_pt(64'h0001020304050607, 1, 7);
    check("held_byte_start", {79'd0, core_start}, 80'd1);
    check("held_byte_din", {16'd0, core_din}, {16'd0, 64'h5A01020304050607});
    core_reply(1, 64'h1122334455667788);
    drain(64'h1122334455667788, 1'b0);

    // Spurious done in LOAD
    core_done = 1'b1; core_dout = 64'hDEADBEEFDEADBEEF;
    step();
    core_done = 1'b0;
    check("spur_load_ready", {79'd0, s_ready}, 80'd1);
    check("spur_load_valid", {79'd0, m_valid}, 80'd0);
    check("spur_load_busy", {79'd0, busy}, 80'd0);

    // Done coincident with the last timeout cycle, then spurious done in DRAIN
    load_pt(64'h1111111111111111, 0, 8);
    core_reply(16, 64'hC0FFEE0012345678);
    check("simul_valid", {79'd0, m_valid}, 80'd1);
    check("simul_err", {79'd0, err_timeout}, 80'd0);
    m_ready = 1'b0;
    core_done = 1'b1; core_dout = 64'h3F0011EDCBA98765;
    step();
    core_done = 1'b0;
    check("spur_drain_data", {72'd0, m_data}, 80'hC0);
    drain(64'hC0FFEE0012345678, 1'b0);
    check("simul_err_after", {79'd0, err_timeout}, 80'd0);

    // Timeout: done never arrives
    load_pt(64'hFEDCBA9876543210, 0, 8);
    check("to_start", {79'd0, core_start}, 80'd1);
    step();
    for (int c = 1; c < 16; c++) begin
      step();
      check("to_no_valid", {79'd0, m_valid}, 80'd0);
    end
    check("to_err_pre", {79'd0, err_timeout}, 80'd0);
    check("to_busy_pre", {79'd0, busy}, 80'd1);
    step();
    check("to_err", {79'd0, err_timeout}, 80'd1);
    check("to_load", {79'd0, s_ready}, 80'd1);
    check("to_busy", {79'd0, busy}, 80'd0);
    load_pt(64'h0F0E0D0C0B0A0908, 0, 8);
    core_reply(4, 64'h8877665544332211);
    drain(64'h8877665544332211, 1'b0);
    check("to_err_sticky", {79'd0, err_timeout}, 80'd1);

    // Reset after five plaintext bytes
    load_pt(64'h2222222222222222, 0, 5);
    reset_pulse();
    load_key(80'h0123456789ABCDEF0123);
    load_pt(64'h3131313131313131, 0, 7);
    check("partial_no_start", {79'd0, core_start}, 80'd0);
    check("partial_ready", {79'd0, s_ready}, 80'd1);
    load_pt(64'h3131313131313131, 7, 1);
    check("full_start", {79'd0, core_start}, 80'd1);
    check("full_din", {16'd0, core_din}, {16'd0, 64'h3131313131313131});

    // Reset during DRAIN
    core_reply(2, 64'h5555AAAA5555AAAA);
    m_ready = 1'b0;
    step();
    check("pre_rst_valid", {79'd0, m_valid}, 80'd1);
    reset_pulse();
    m_ready = 1'b1;
    load_key(80'd0);
    load_pt(64'd0, 0, 8);
    core_reply(2, CT_ZERO);
    drain(CT_ZERO, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/present_byte_if.md
# present_byte_if

Byte-stream front/back end for the PRESENT-80 core (`present_top`). It assembles an 80-bit key and a 64-bit plaintext block from an 8-bit valid/ready input stream, then drives the core's `start`/`din`/`key`. It waits for `done` and captures `dout`, then serialises the 64-bit ciphertext onto an 8-bit valid/ready output stream. It sits directly between the system byte bus and `present_top`, and replaces the stimulus-driven `start` pulse used in core-level simulation.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before aborting. Legal range 1..65535; the counter is 16 bits.
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: reset, asynchronous, active-low. A low level forces the reset values immediately.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: input byte accepted when `s_valid && s_ready`.
- `s_data` in 8: input byte.
- `s_key` in 1: qualifies `s_data`. 1 = key byte, 0 = plaintext byte.
- `core_start` out 1: start pulse to `present_top.start`.
- `core_din` out 64: plaintext to `present_top.din`.
- `core_key` out 80: key to `present_top.key`.
- `core_dout` in 64: ciphertext from `present_top.dout`.
- `core_done` in 1: completion from `present_top.done`.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: output byte consumed when `m_valid && m_ready`.
- `m_data` out 8: output ciphertext byte, MSB first.
- `busy` out 1: high in START, WAIT and DRAIN.
- `err_timeout` out 1: sticky flag, set on WAIT timeout, cleared only by reset.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN. Reset state is IDLE.
- IDLE:
  - goes to LOAD on the next edge, unconditionally.
- LOAD:
  - `s_ready`=1.
  - Key byte accepted: `core_key <= {core_key[71:0], s_data}`. Any number of key bytes is allowed; the last 10 accepted form the key. The key persists across blocks until overwritten.
  - Plaintext byte accepted: `core_din <= {core_din[55:0], s_data}` and byte counter `bcnt` (3 bits) increments.
  - Acceptance of the 8th plaintext byte (`bcnt`==7): `bcnt` wraps to 0 and the next state is START.
- START:
  - `core_start`=1 for exactly this one cycle.
  - The timeout counter `tcnt` clears to 0.
  - Next state is WAIT.
- WAIT:
  - `tcnt` increments each cycle.
  - `core_done`=1: `dout_sr <= core_dout`, next state DRAIN. This takes priority over timeout in the same cycle.
  - `core_done`=0 and `tcnt`==TIMEOUT-1: `err_timeout` is set, next state LOAD, and the block is discarded with no output.
- DRAIN:
  - `m_valid`=1, `m_data`=`dout_sr[63:56]`.
  - On handshake: `dout_sr` shifts left 8 and output counter `ocnt` increments.
  - After the 8th handshake: `ocnt` wraps to 0, next state LOAD.
- `core_din` and `core_key` are modified only in LOAD. They are therefore stable from START through the end of WAIT, which satisfies the core's hold requirement.
- `core_done` outside WAIT is ignored.
- `s_ready`=0 outside LOAD. Input bytes presented then are held by the source, not dropped.
- `err_timeout` does not block operation. Subsequent blocks process normally.

## Timing
- Reset values (while `RST`=0):
  - all outputs are 0: `s_ready`, `core_start`, `core_din`, `core_key`, `m_valid`, `m_data`, `busy`, `err_timeout`;
  - internal state: `bcnt`=`ocnt`=`tcnt`=0, `dout_sr`=0, state IDLE.
- After release: IDLE lasts 1 cycle. `s_ready`=1 from the 2nd cycle after release.
- Outputs are decoded from registered state and registers; there are no combinational paths from inputs to outputs.
- 8th plaintext byte accepted in cycle N:
  - `core_start`=1 in cycle N+1 only;
  - WAIT from N+2.
- `core_done` sampled high in cycle M:
  - `m_valid`=1 with byte 0 (`dout[63:56]`) in M+1;
  - `busy` remains 1.
- With `m_ready` held at 1, bytes appear on 8 consecutive cycles.
- The last handshake in cycle K gives LOAD and `s_ready`=1 in K+1.
- When `m_ready`=0, `m_valid` and `m_data` hold unchanged.
- Timeout:
  - WAIT is entered at N+2, so if `core_done` never rises, LOAD is re-entered TIMEOUT cycles later;
  - `err_timeout` rises in the same cycle as that LOAD entry.
- Asynchronous reset mid-operation (any state) returns to IDLE, discards partial key, plaintext and output data, and drops `core_start`/`m_valid` immediately.

## Test plan
- Basic vector:
  - Stimulus: 10 key bytes 0x00, 8 plaintext bytes 0x00, real `present_top`, `m_ready`=1.
  - Required: one `core_start` pulse, then output bytes 55 79 C1 38 7B 22 84 45.
- Key reuse:
  - Stimulus: key bytes all 0xFF, then two blocks of plaintext 0x00 without reloading the key.
  - Required: both blocks output E7 2C 46 C0 F5 94 50 49.
- Backpressure:
  - Stimulus: `m_ready` toggled 1,0,0,1,... during DRAIN; `s_valid` held high with data during DRAIN.
  - Required: `m_data` stable while stalled, exactly 8 bytes in order, `s_ready`=0 until the cycle after the last handshake, no input bytes lost.
- Timeout:
  - Stimulus: core model never asserts `done`, `TIMEOUT`=16.
  - Required: `err_timeout`=1 and state LOAD 16 cycles after WAIT entry, no `m_valid`; the next block with a working core completes normally with `err_timeout` still 1.
- Spurious and simultaneous done:
  - Stimulus: `core_done` pulsed in LOAD and in DRAIN, and asserted in the same cycle as `tcnt`==TIMEOUT-1.
  - Required: the pulses in LOAD and DRAIN are ignored; in the simultaneous case the ciphertext is captured, DRAIN is entered, and `err_timeout` stays 0.
- Reset mid-block:
  - Stimulus: `RST` low after 5 plaintext bytes and again during DRAIN.
  - Required: all outputs 0 immediately; after release the full 8-byte block is needed before `core_start`.
